// File: rtl/hazard_scoreboard_pkg.sv
// +--------------------------------------------------------------------------+
// | hazard_scoreboard_pkg                                                    |
// | Shared constants and helpers for the hazard scoreboard and match finder. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package hazard_scoreboard_pkg;

  localparam int c_fwd_sel_rf = 0;
  localparam int c_stg_e      = 1;
  localparam int c_stg_m      = 2;
  localparam int c_stg_w      = 3;

  localparam int c_mdu_mult_cycles_def = 5;
  localparam int c_mdu_div_cycles_def  = 10;

  // All-ones Tuse encoding marks an operand that is never read.
  function automatic int tuse_none(input int width);
    return (1 << width) - 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_match.sv
// +--------------------------------------------------------------------------+
// | hazard_match                                                             |
// | Youngest-match priority finder over a window of scoreboard entries.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module hazard_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_ENT    = 3,
  parameter int BASE       = 1,
  parameter int REG_ADDR_W = 5,
  parameter int TNEW_W     = 2,
  parameter int SEL_W      = 2
) (
  input  logic [NUM_ENT-1:0]                 valid,
  input  logic [NUM_ENT-1:0][REG_ADDR_W-1:0] dest,
  input  logic [NUM_ENT-1:0][TNEW_W-1:0]     tnew,
  input  logic [REG_ADDR_W-1:0]              addr,
  output logic                               hit,
  output logic [TNEW_W-1:0]                  hit_tnew,
  output logic [SEL_W-1:0]                   sel
);

  logic [SEL_W-1:0] w_idx;

  // Scan oldest to youngest so the youngest matching entry overwrites the rest.
  always_comb begin
    hit      = 1'b0;
    hit_tnew = '0;
    w_idx    = SEL_W'(c_fwd_sel_rf);
    for (int i = NUM_ENT - 1; i >= 0; i--) begin
      if (valid[i] && (dest[i] != '0) && (dest[i] == addr)) begin
        hit      = 1'b1;
        hit_tnew = tnew[i];
        w_idx    = SEL_W'(i + BASE);
      end
    end
  end

  always_comb begin
    sel = SEL_W'(c_fwd_sel_rf);
    if (hit && (hit_tnew == '0)) begin
      sel = w_idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// +--------------------------------------------------------------------------+
// | hazard_scoreboard                                                        |
// | In-flight destination tracker producing D stall and D/E forward selects. |
// | Optional MDU busy tracking enabled by macro HAZARD_MDU_STALL_EN.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_STAGES      = 3,
  parameter int REG_ADDR_W      = 5,
  parameter int TNEW_W          = 2,
  parameter int MDU_MULT_CYCLES = c_mdu_mult_cycles_def,
  parameter int MDU_DIV_CYCLES  = c_mdu_div_cycles_def,
  localparam int SEL_W          = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  d_valid,
  input  logic [REG_ADDR_W-1:0] d_rs_addr,
  input  logic [TNEW_W-1:0]     d_rs_tuse,
  input  logic [REG_ADDR_W-1:0] d_rt_addr,
  input  logic [TNEW_W-1:0]     d_rt_tuse,
  input  logic [REG_ADDR_W-1:0] d_dest_addr,
  input  logic [TNEW_W-1:0]     d_tnew,
  input  logic                  d_mdu_start,
  input  logic                  d_mdu_is_div,
  input  logic                  d_mdu_use,
  output logic                  stall,
  output logic [SEL_W-1:0]      fwd_d1,
  output logic [SEL_W-1:0]      fwd_d2,
  output logic [SEL_W-1:0]      fwd_e1,
  output logic [SEL_W-1:0]      fwd_e2,
  output logic                  mdu_busy
);

  localparam logic [TNEW_W-1:0] c_tuse_none = TNEW_W'(tuse_none(TNEW_W));

  // Index 0 is the E stage; index k holds stage k+1.
  logic [NUM_STAGES-1:0]                 r_valid;
  logic [NUM_STAGES-1:0][REG_ADDR_W-1:0] r_dest;
  logic [NUM_STAGES-1:0][TNEW_W-1:0]     r_tnew;
  logic [REG_ADDR_W-1:0]                 r_e_rs;
  logic [REG_ADDR_W-1:0]                 r_e_rt;

  logic              w_d1_hit, w_d2_hit, w_e1_hit, w_e2_hit;
  logic [TNEW_W-1:0] w_d1_tnew, w_d2_tnew, w_e1_tnew, w_e2_tnew;
  logic [SEL_W-1:0]  w_d1_sel, w_d2_sel, w_e1_sel, w_e2_sel;
  logic              w_haz_rs, w_haz_rt;
  logic              w_mdu_busy, w_mdu_stall;
  logic              w_stall_raw;
  logic              w_unused_e;

  hazard_match #(
    .NUM_ENT(NUM_STAGES), .BASE(c_stg_e), .REG_ADDR_W(REG_ADDR_W),
    .TNEW_W(TNEW_W), .SEL_W(SEL_W)
  ) u_match_d1 (
    .valid(r_valid), .dest(r_dest), .tnew(r_tnew), .addr(d_rs_addr),
    .hit(w_d1_hit), .hit_tnew(w_d1_tnew), .sel(w_d1_sel)
  );

  hazard_match #(
    .NUM_ENT(NUM_STAGES), .BASE(c_stg_e), .REG_ADDR_W(REG_ADDR_W),
    .TNEW_W(TNEW_W), .SEL_W(SEL_W)
  ) u_match_d2 (
    .valid(r_valid), .dest(r_dest), .tnew(r_tnew), .addr(d_rt_addr),
    .hit(w_d2_hit), .hit_tnew(w_d2_tnew), .sel(w_d2_sel)
  );

  // E-stage operands can only be fed from stages older than E itself.
  hazard_match #(
    .NUM_ENT(NUM_STAGES - 1), .BASE(c_stg_m), .REG_ADDR_W(REG_ADDR_W),
    .TNEW_W(TNEW_W), .SEL_W(SEL_W)
  ) u_match_e1 (
    .valid(r_valid[NUM_STAGES-1:1]), .dest(r_dest[NUM_STAGES-1:1]),
    .tnew(r_tnew[NUM_STAGES-1:1]), .addr(r_e_rs),
    .hit(w_e1_hit), .hit_tnew(w_e1_tnew), .sel(w_e1_sel)
  );

  hazard_match #(
    .NUM_ENT(NUM_STAGES - 1), .BASE(c_stg_m), .REG_ADDR_W(REG_ADDR_W),
    .TNEW_W(TNEW_W), .SEL_W(SEL_W)
  ) u_match_e2 (
    .valid(r_valid[NUM_STAGES-1:1]), .dest(r_dest[NUM_STAGES-1:1]),
    .tnew(r_tnew[NUM_STAGES-1:1]), .addr(r_e_rt),
    .hit(w_e2_hit), .hit_tnew(w_e2_tnew), .sel(w_e2_sel)
  );

  assign w_unused_e = ^{w_e1_hit, w_e2_hit, w_e1_tnew, w_e2_tnew};

  assign w_haz_rs = d_valid && (d_rs_addr != '0) && (d_rs_tuse != c_tuse_none)
                    && w_d1_hit && (w_d1_tnew > d_rs_tuse);
  assign w_haz_rt = d_valid && (d_rt_addr != '0) && (d_rt_tuse != c_tuse_none)
                    && w_d2_hit && (w_d2_tnew > d_rt_tuse);

`ifdef HAZARD_MDU_STALL_EN
  localparam int c_mdu_cnt_w = $clog2(max_int(MDU_MULT_CYCLES, MDU_DIV_CYCLES) + 1);

  logic [c_mdu_cnt_w-1:0] r_mdu_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mdu_cnt <= '0;
    end else if (d_mdu_start && d_valid && !w_stall_raw) begin
      r_mdu_cnt <= d_mdu_is_div ? c_mdu_cnt_w'(MDU_DIV_CYCLES)
                                : c_mdu_cnt_w'(MDU_MULT_CYCLES);
    end else if (r_mdu_cnt != '0) begin
      r_mdu_cnt <= r_mdu_cnt - c_mdu_cnt_w'(1);
    end
  end

  assign w_mdu_busy  = (r_mdu_cnt != '0);
  assign w_mdu_stall = d_valid && d_mdu_use && w_mdu_busy;
`else
  logic w_unused_mdu;

  assign w_unused_mdu = ^{d_mdu_start, d_mdu_is_div, d_mdu_use,
                          (MDU_MULT_CYCLES != 0), (MDU_DIV_CYCLES != 0)};
  assign w_mdu_busy   = 1'b0;
  assign w_mdu_stall  = 1'b0;
`endif

  assign w_stall_raw = w_haz_rs || w_haz_rt || w_mdu_stall;

  // Reset masks outputs in the same cycle it is asserted, not just after.
  assign stall    = !reset && w_stall_raw;
  assign mdu_busy = !reset && w_mdu_busy;
  assign fwd_d1   = reset ? SEL_W'(c_fwd_sel_rf) : w_d1_sel;
  assign fwd_d2   = reset ? SEL_W'(c_fwd_sel_rf) : w_d2_sel;
  assign fwd_e1   = reset ? SEL_W'(c_fwd_sel_rf) : w_e1_sel;
  assign fwd_e2   = reset ? SEL_W'(c_fwd_sel_rf) : w_e2_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_dest  <= '0;
      r_tnew  <= '0;
      r_e_rs  <= '0;
      r_e_rt  <= '0;
    end else begin
      if (d_valid && !w_stall_raw) begin
        r_valid[0] <= 1'b1;
        r_dest[0]  <= d_dest_addr;
        r_tnew[0]  <= d_tnew;
        r_e_rs     <= d_rs_addr;
        r_e_rt     <= d_rt_addr;
      end else begin
        r_valid[0] <= 1'b0;
        r_dest[0]  <= '0;
        r_tnew[0]  <= '0;
        r_e_rs     <= '0;
        r_e_rt     <= '0;
      end
      for (int k = 1; k < NUM_STAGES; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_dest[k]  <= r_dest[k-1];
        r_tnew[k]  <= (r_tnew[k-1] == '0) ? '0 : r_tnew[k-1] - TNEW_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// +--------------------------------------------------------------------------+
// | tb_hazard_scoreboard                                                     |
// | Directed and random checks of hazard_scoreboard against a timeline model.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_hazard_scoreboard;

  localparam int NS       = 3;
  localparam int AW       = 5;
  localparam int TW       = 2;
  localparam int SW       = 2;
  localparam int NONE     = 3;
  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          d_valid;
  logic [AW-1:0] d_rs_addr, d_rt_addr, d_dest_addr;
  logic [TW-1:0] d_rs_tuse, d_rt_tuse, d_tnew;
  logic          d_mdu_start, d_mdu_is_div, d_mdu_use;
  logic          stall, mdu_busy;
  logic [SW-1:0] fwd_d1, fwd_d2, fwd_e1, fwd_e2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NUM_STAGES(NS), .REG_ADDR_W(AW), .TNEW_W(TW),
    .MDU_MULT_CYCLES(MULT_CYC), .MDU_DIV_CYCLES(DIV_CYC)
  ) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid),
    .d_rs_addr(d_rs_addr), .d_rs_tuse(d_rs_tuse),
    .d_rt_addr(d_rt_addr), .d_rt_tuse(d_rt_tuse),
    .d_dest_addr(d_dest_addr), .d_tnew(d_tnew),
    .d_mdu_start(d_mdu_start), .d_mdu_is_div(d_mdu_is_div), .d_mdu_use(d_mdu_use),
    .stall(stall), .fwd_d1(fwd_d1), .fwd_d2(fwd_d2),
    .fwd_e1(fwd_e1), .fwd_e2(fwd_e2), .mdu_busy(mdu_busy)
  );

  // Model: each accepted instruction remembers the cycle it left D.
  // In cycle n it sits in stage n-acc with remaining latency tnew-(stage-1).
  typedef struct {int acc; int dest; int tnew; int rs; int rt;} instr_t;
  instr_t q[$];
  int     n = 0;
  bit     mdu_v = 0;
  int     mdu_acc = 0;
  int     mdu_len = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %0d expected %0d", tag, n, obs, exp);
    end
  endtask

  function automatic void lookup(input int addr, input int kmin, output int k, output int rem);
    k = 0;
    rem = 0;
    foreach (q[i]) begin
      int st;
      st = n - q[i].acc;
      if (st >= kmin && st <= NS && q[i].dest != 0 && q[i].dest == addr && (k == 0 || st < k)) begin
        k = st;
        rem = q[i].tnew - (st - 1);
        if (rem < 0) rem = 0;
      end
    end
  endfunction

  task automatic set_d(input bit v, input int rs, input int rsu, input int rt, input int rtu,
                       input int dest, input int tn, input bit ms, input bit md, input bit mu);
    d_valid = v;
    d_rs_addr = AW'(rs);  d_rs_tuse = TW'(rsu);
    d_rt_addr = AW'(rt);  d_rt_tuse = TW'(rtu);
    d_dest_addr = AW'(dest); d_tnew = TW'(tn);
    d_mdu_start = ms; d_mdu_is_div = md; d_mdu_use = mu;
  endtask

  task automatic idle();
    set_d(0, 0, NONE, 0, NONE, 0, 0, 0, 0, 0);
  endtask

  // Checks every output for the current cycle, then advances the model over the edge.
  task automatic do_cycle();
    int k1, r1, k2, r2, ke1, re1, ke2, re2, ers, ert;
    bit busy, s;
    int ef1, ef2, ee1, ee2;
    #1;
    lookup(int'(d_rs_addr), 1, k1, r1);
    lookup(int'(d_rt_addr), 1, k2, r2);
    ers = 0;
    ert = 0;
    foreach (q[i]) if (q[i].acc == n - 1) begin ers = q[i].rs; ert = q[i].rt; end
    lookup(ers, 2, ke1, re1);
    lookup(ert, 2, ke2, re2);
    busy = 0;
`ifdef HAZARD_MDU_STALL_EN
    busy = mdu_v && (n - mdu_acc >= 1) && (n - mdu_acc <= mdu_len);
`endif
    s = (d_valid && d_rs_addr != 0 && int'(d_rs_tuse) != NONE && k1 != 0 && r1 > int'(d_rs_tuse))
     || (d_valid && d_rt_addr != 0 && int'(d_rt_tuse) != NONE && k2 != 0 && r2 > int'(d_rt_tuse))
     || (d_valid && d_mdu_use && busy);
    ef1 = (k1 != 0 && r1 == 0) ? k1 : 0;
    ef2 = (k2 != 0 && r2 == 0) ? k2 : 0;
    ee1 = (ke1 != 0 && re1 == 0) ? ke1 : 0;
    ee2 = (ke2 != 0 && re2 == 0) ? ke2 : 0;
    if (reset) begin
      s = 0; busy = 0; ef1 = 0; ef2 = 0; ee1 = 0; ee2 = 0;
    end
    chk("stall",    32'(stall),    32'(s));
    chk("mdu_busy", 32'(mdu_busy), 32'(busy));
    chk("fwd_d1",   32'(fwd_d1),   32'(ef1));
    chk("fwd_d2",   32'(fwd_d2),   32'(ef2));
    chk("fwd_e1",   32'(fwd_e1),   32'(ee1));
    chk("fwd_e2",   32'(fwd_e2),   32'(ee2));
    if (reset) begin
      q.delete();
      mdu_v = 0;
    end else if (d_valid && !s) begin
      q.push_back('{n, int'(d_dest_addr), int'(d_tnew), int'(d_rs_addr), int'(d_rt_addr)});
`ifdef HAZARD_MDU_STALL_EN
      if (d_mdu_start) begin
        mdu_v = 1;
        mdu_acc = n;
        mdu_len = d_mdu_is_div ? DIV_CYC : MULT_CYC;
      end
`endif
    end
    @(posedge clk);
    #1;
    n++;
    while (q.size() > 0 && n - q[0].acc > NS) void'(q.pop_front());
  endtask

  task automatic flush();
    idle();
    repeat (4) do_cycle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    do_cycle();
    do_cycle();
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_fwd_d1", 32'(fwd_d1), 32'd0);
    reset = 1'b0;
    flush();

    // ALU result one cycle away meets a consumer with matching Tuse.
    set_d(1, 0, NONE, 0, NONE, 3, 1, 0, 0, 0); do_cycle();
    set_d(1, 3, 1, 0, NONE, 0, 0, 0, 0, 0); #1;
    chk("t1_stall", 32'(stall), 32'd0);
    chk("t1_fwd_d1", 32'(fwd_d1), 32'd0);
    do_cycle();
    idle(); #1;
    chk("t1_fwd_e1", 32'(fwd_e1), 32'd2);
    flush();

    // Load-use into a branch: two stall cycles then forward from W.
    set_d(1, 0, NONE, 0, NONE, 4, 2, 0, 0, 0); do_cycle();
    set_d(1, 4, 0, 0, NONE, 0, 0, 0, 0, 0); #1;
    chk("t2_stall_a", 32'(stall), 32'd1);
    do_cycle(); #1;
    chk("t2_stall_b", 32'(stall), 32'd1);
    do_cycle(); #1;
    chk("t2_stall_c", 32'(stall), 32'd0);
    chk("t2_fwd_d1", 32'(fwd_d1), 32'd3);
    do_cycle();
    flush();

    // $0 is never a hazard.
    set_d(1, 0, NONE, 0, NONE, 0, 2, 0, 0, 0); do_cycle();
    set_d(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("t3_stall", 32'(stall), 32'd0);
    chk("t3_fwd_d1", 32'(fwd_d1), 32'd0);
    do_cycle();
    flush();

    // Two producers of $5: the younger one in E wins.
    set_d(1, 0, NONE, 0, NONE, 5, 0, 0, 0, 0); do_cycle();
    set_d(1, 0, NONE, 0, NONE, 5, 0, 0, 0, 0); do_cycle();
    set_d(1, 5, 0, 5, 0, 0, 0, 0, 0, 0); #1;
    chk("t4_fwd_d1", 32'(fwd_d1), 32'd1);
    chk("t4_fwd_d2", 32'(fwd_d2), 32'd1);
    do_cycle();
    flush();

    // mult followed by mfhi.
    set_d(1, 1, 0, 2, 0, 0, 0, 1, 0, 1); do_cycle();
    set_d(1, 0, NONE, 0, NONE, 7, 0, 0, 0, 1);
    for (int i = 1; i <= 6; i++) begin
      #1;
`ifdef HAZARD_MDU_STALL_EN
      chk("t5_stall", 32'(stall), (i <= 5) ? 32'd1 : 32'd0);
      chk("t5_busy", 32'(mdu_busy), (i <= 5) ? 32'd1 : 32'd0);
`else
      chk("t5_stall", 32'(stall), 32'd0);
      chk("t5_busy", 32'(mdu_busy), 32'd0);
`endif
      do_cycle();
    end
    flush();

    // Reset in the middle of a load-use stall.
    set_d(1, 0, NONE, 0, NONE, 4, 2, 0, 0, 0); do_cycle();
    set_d(1, 4, 0, 0, NONE, 0, 0, 0, 0, 0); do_cycle();
    reset = 1'b1; #1;
    chk("t6_stall", 32'(stall), 32'd0);
    chk("t6_fwd_d1", 32'(fwd_d1), 32'd0);
    chk("t6_fwd_e1", 32'(fwd_e1), 32'd0);
    chk("t6_busy", 32'(mdu_busy), 32'd0);
    do_cycle();
    reset = 1'b0; #1;
    chk("t6_after_stall", 32'(stall), 32'd0);
    do_cycle();
    flush();

    // Random traffic over a small register window to provoke frequent matches.
    for (int i = 0; i < 3000; i++) begin
      bit ms;
      reset = ($urandom_range(0, 99) == 0);
      ms = ($urandom_range(0, 19) == 0);
      set_d($urandom_range(0, 9) != 0,
            $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 7), $urandom_range(0, NS - 1),
            ms, $urandom_range(0, 1), ms | ($urandom_range(0, 3) == 0));
      do_cycle();
    end
    reset = 1'b0;
    flush();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
